uart_rx_os16: RTL
=================

# uart_rx_os16

Standalone UART receiver that consumes a 16x-oversampling tick from the team's baud tick generator and deserializes an asynchronous serial line. It synchronizes `rx`, qualifies the start bit at mid-bit, samples data, parity and stop bits at bit centres, and presents each frame on a valid/ready output with parity, framing and overrun status. It sits between the pad-side `rx` line and the APB-facing RX FIFO in the UART top level.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal values 5..8.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `tick` input 1: one-`clk` pulse at 16x the baud rate. Counters advance only in cycles where `tick`=1.
- `rx` input 1: asynchronous serial line, idle high.
- `rx_data` output DATA_BITS: received data, LSB = first bit on the line.
- `rx_valid` output 1: `rx_data` and the error flags are valid.
- `rx_ready` input 1: consumer accepts the frame; transfer occurs when `rx_valid` & `rx_ready`.
- `parity_err` output 1: parity mismatch for the presented frame; qualified by `rx_valid`.
- `frame_err` output 1: a sampled stop bit was 0 for the presented frame; qualified by `rx_valid`.
- `overrun` output 1: one-cycle pulse when a completed frame was discarded.
- `busy` output 1: high in every state except IDLE.

## Operation
- Input synchronizer: 2-flop, both flops reset to 1. `rxs` denotes the synchronized line.
- `tcnt`: 4-bit tick counter. `bcnt`: bit counter. `shreg`: DATA_BITS-wide shift register, filled by right shift with the new bit entering at the MSB.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE
  - When `rxs`=0, go to START with `tcnt`=0.
  - Start detection is level-based and is evaluated every `clk`, independent of `tick`.
- START
  - On the tick with `tcnt`=7 (the 8th tick), sample `rxs`.
  - If the sample is 0, go to DATA with `tcnt`=0 and `bcnt`=0.
  - If the sample is 1, the start bit is a glitch: go to IDLE. No output and no error are produced.
- DATA
  - On the tick with `tcnt`=15, shift `rxs` into `shreg`, reset `tcnt` to 0, and increment `bcnt`.
  - After bit DATA_BITS-1, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY
  - On the tick with `tcnt`=15, compute `perr` = XOR of all data bits XOR the parity bit XOR `PARITY_ODD`.
  - Then go to STOP.
- STOP
  - On the tick with `tcnt`=15, sample `rxs`. A sample of 0 sets `ferr`.
  - If `STOP_BITS`=2, a second sample is taken 16 ticks later, and either sample being 0 sets `ferr`.
  - After the final stop sample the frame is complete, and no remaining stop time is waited out.
  - Next state is IDLE if `ferr`=0, or WAIT_HIGH if `ferr`=1.
- WAIT_HIGH (break or framing recovery)
  - Stay in this state until `rxs`=1, then go to IDLE.
  - A line held low never re-triggers start detection.
- Output register (frame completion)
  - If `rx_valid`=0, or `rx_valid` & `rx_ready` in the same cycle: load `rx_data`=`shreg`, `parity_err`=`perr`, `frame_err`=`ferr`, and set `rx_valid`=1.
  - Otherwise: discard the new frame, keep the held frame unchanged, and pulse `overrun`=1 for one cycle.
- Handshake
  - `rx_valid`, `rx_data` and both error flags stay stable while `rx_valid` & !`rx_ready`.
  - A handshake with no simultaneous completion clears `rx_valid` on the next edge.
- Reset
  - All outputs reset to 0: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM resets to IDLE, counters to 0.
  - An in-progress frame is dropped, and no partial data reaches the outputs.

## Timing
- `rx` to `rxs`: 2 `clk`.
- Start-bit centre: 8 ticks after `rxs` falls. Each following sample is 16 ticks after the previous one.
- `rx_valid` rises on the `clk` edge after the `tick` cycle on which the final stop bit is sampled.
- `overrun` pulses on that same edge instead.
- `busy` rises on the `clk` edge after `rxs` is first seen low in IDLE. It falls on the edge where the FSM enters IDLE.
- With the frame consumed in time, back-to-back frames, with the next start edge immediately after the stop-bit centre, are received without loss.

## Test plan
- 8N1, `tick` every 4 `clk`, send 0xA5 → `rx_data`=0xA5, `rx_valid`=1, `parity_err`=0, `frame_err`=0. Hold `rx_ready`=0 for 20 cycles → outputs stable; then assert `rx_ready` → `rx_valid`=0 next cycle.
- Glitch: drive `rx` low for 5 ticks, then high → FSM returns to IDLE, `rx_valid` stays 0, `busy` pulses, and no error flag is set.
- `PARITY_EN`=1, `PARITY_ODD`=0, send 0x37 (five 1s) with parity bit 0 → `rx_data`=0x37, `parity_err`=1. Resend with parity bit 1 → `parity_err`=0.
- Stop bit 0 for data 0x00, then `rx` held low 100 ticks → one frame with `frame_err`=1 and `rx_data`=0x00. No further frame until `rx` returns high. A following 0x5A is received cleanly.
- Overrun: send 0x11 then 0x22 back-to-back with `rx_ready`=0 → `overrun` pulses once at the end of the second frame and `rx_data` stays 0x11. Completion coinciding with a handshake → 0x22 is loaded and no `overrun` pulse occurs.
- `STOP_BITS`=2 with a second stop bit of 0 → `frame_err`=1. Reset asserted mid-DATA → all outputs 0 and FSM in IDLE; the next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_os16.sv
// uart_rx_os16
// UART receiver driven by a 16x oversampling tick. The rx line is
// synchronized, the start bit is confirmed at its centre, and data, optional
// parity and the stop bit(s) are sampled at bit centres. Each completed
// frame is offered on a valid/ready output together with parity and framing
// status; a frame that completes while the previous one is still unread is
// dropped and reported on the overrun pulse.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   tick       one-clk pulse at 16x baud; counters advance only on ticks
//   rx         asynchronous serial input, idle high
//   rx_data    received data, LSB = first bit on the line
//   rx_valid   rx_data and error flags are valid
//   rx_ready   consumer accepts the presented frame
//   parity_err parity mismatch for the presented frame
//   frame_err  a sampled stop bit was 0 for the presented frame
//   overrun    one-cycle pulse when a completed frame was discarded
//   busy       receiver is not idle
module uart_rx_os16 #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t               state_reg, state_next;
  logic [3:0]           tcnt_reg, tcnt_next;
  logic [2:0]           bcnt_reg, bcnt_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 frame_done;
  logic                 sync1_reg, rxs;

  // Two-flop synchronizer; both stages reset to the idle (high) level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rxs       <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      tcnt_reg  <= '0;
      bcnt_reg  <= '0;
      shreg_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
      bcnt_reg  <= bcnt_next;
      shreg_reg <= shreg_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tcnt_next  = tcnt_reg;
    bcnt_next  = bcnt_reg;
    shreg_next = shreg_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    frame_done = 1'b0;

    case (state_reg)
      IDLE: begin
        // Level-based start detection, evaluated every clk.
        if (!rxs) begin
          state_next = START;
          tcnt_next  = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tcnt_reg == 4'd7) begin
            if (!rxs) begin
              state_next = DATA;
              tcnt_next  = '0;
              bcnt_next  = '0;
              perr_next  = 1'b0;
              ferr_next  = 1'b0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state_next = IDLE;
            end
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tcnt_reg == 4'd15) begin
            shreg_next = {rxs, shreg_reg[DATA_BITS-1:1]};
            tcnt_next  = '0;
            if (bcnt_reg == 3'(DATA_BITS - 1)) begin
              bcnt_next  = '0;
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bcnt_next = bcnt_reg + 3'd1;
            end
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (tcnt_reg == 4'd15) begin
            perr_next  = (^shreg_reg) ^ rxs ^ (PARITY_ODD != 0);
            tcnt_next  = '0;
            bcnt_next  = '0;
            state_next = STOP;
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tcnt_reg == 4'd15) begin
            ferr_next = ferr_reg | ~rxs;
            tcnt_next = '0;
            if (bcnt_reg == 3'(STOP_BITS - 1)) begin
              // Frame completes at the last stop-bit centre; the rest of
              // the stop time is not waited out so a following start edge
              // is caught immediately.
              frame_done = 1'b1;
              bcnt_next  = '0;
              state_next = (ferr_reg | ~rxs) ? WAIT_HIGH : IDLE;
            end else begin
              bcnt_next = bcnt_reg + 3'd1;
            end
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end
      end

      WAIT_HIGH: begin
        // A break (line held low) must not re-trigger start detection.
        if (rxs) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);

  // Output holding register. A completed frame is loaded when the register
  // is empty or is being read in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg_reg;
          parity_err <= perr_reg;
          frame_err  <= ferr_next;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
